// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, register typedefs, PC index and pending-count width helper
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_PC_IDX = 15;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  function automatic int cnt_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction
endpackage

// File: rtl/rf_pending_ctr.sv
// rf_pending_ctr: saturating pending-write counter (inc/dec in, count/full/zero/underflow out)
module rf_pending_ctr #(
  parameter int MAX_PEND = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         zero,
  output logic         underflow
);
  assign full = count == W'(MAX_PEND);
  assign zero = count == '0;
  assign underflow = dec && zero;
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (inc && !dec && !full) count <= count + 1'b1;
    else if (dec && !inc && !zero) count <= count - 1'b1;
  end
endmodule

// File: rtl/scoreboarded_register_file.sv
// scoreboarded_register_file: 2R/1W regfile with bypass and pending-write scoreboard; reads ra/rd/rdy, issue alloc_en/alloc_addr/alloc_ok, write-back wb_*, stall and sticky err out
module scoreboarded_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int MAX_PEND = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              use1,
  input  logic              use2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rdy1,
  output logic              rdy2,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ok,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              err
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam int CW = cnt_w(MAX_PEND);
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
  logic [DATA_W-1:0] regs [NREGS];
  logic [CW-1:0] cnt [NREGS];
  logic [NREGS-1:0] full, zero, unf;
  logic hit1, hit2, stall_op, full_a;
  always_comb begin
    hit1 = BYPASS && wb_en && wb_addr == ra1;
    hit2 = BYPASS && wb_en && wb_addr == ra2;
    rd1 = ra1 == PC_A ? pc_in : hit1 ? wb_data : regs[ra1];
    rd2 = ra2 == PC_A ? pc_in : hit2 ? wb_data : regs[ra2];
    rdy1 = ra1 == PC_A || zero[ra1] || (hit1 && cnt[ra1] == CW'(1));
    rdy2 = ra2 == PC_A || zero[ra2] || (hit2 && cnt[ra2] == CW'(1));
    stall_op = (use1 && !rdy1) || (use2 && !rdy2);
    full_a = alloc_addr != PC_A && full[alloc_addr] && !(wb_en && wb_addr == alloc_addr);
    alloc_ok = alloc_en && !full_a && !stall_op;
    stall = stall_op || (alloc_en && !alloc_ok);
  end
  for (genvar r = 0; r < NREGS; r++) begin : g_ctr
    localparam bit LIVE = r != PC_IDX;
    rf_pending_ctr #(.MAX_PEND(MAX_PEND), .W(CW)) u_ctr (
      .clk(clk),
      .reset(reset),
      .inc(LIVE && alloc_ok && alloc_addr == ADDR_W'(r)),
      .dec(LIVE && wb_en && wb_addr == ADDR_W'(r)),
      .count(cnt[r]),
      .full(full[r]),
      .zero(zero[r]),
      .underflow(unf[r])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      err <= 1'b0;
    end else begin
      if (wb_en && wb_addr != PC_A) regs[wb_addr] <= wb_data;
      if (|unf) err <= 1'b1;
    end
  end
endmodule
